// File: rtl/mic_array_capture.sv
`default_nettype none
// ============================================================================
// Module : mic_array_capture
// Brief  : N-channel I2S mic capture engine. Generates SCK/WS, deserialises the
//          left-slot word of every line and streams block captures over valid/ready.
// Rev    : 1.0  initial release
// ============================================================================
module mic_array_capture #(
    parameter int CH_NUM    = 4,
    parameter int DATA_W    = 24,
    parameter int SLOT_BITS = 32,
    parameter int SCK_DIV   = 30,
    parameter int FRAME_LEN = 256
) (
    input  logic                          clk_60MHz,
    input  logic                          rst_n,
    input  logic                          cap_start,
    output logic                          cap_busy,
    output logic                          cap_done,
    output logic                          overrun,
    output logic                          mic_sck,
    output logic                          mic_ws,
    input  logic [CH_NUM-1:0]             mic_data_in,
    output logic                          smp_valid,
    input  logic                          smp_ready,
    output logic [CH_NUM*DATA_W-1:0]      smp_data,
    output logic [$clog2(FRAME_LEN)-1:0]  smp_index
);

    localparam int DIV_W = $clog2(SCK_DIV);
    localparam int BC_W  = $clog2(2*SLOT_BITS);
    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam int WC_W  = $clog2(FRAME_LEN+1);

    localparam logic [DIV_W-1:0] DIV_RISE   = DIV_W'(SCK_DIV/2 - 1);
    localparam logic [DIV_W-1:0] DIV_FALL   = DIV_W'(SCK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_STROBE = DIV_W'(SCK_DIV/2 + 1);
    localparam logic [BC_W-1:0]  BC_LAST    = BC_W'(2*SLOT_BITS - 1);
    localparam logic [BC_W-1:0]  BC_SLOT    = BC_W'(SLOT_BITS);
    localparam logic [BC_W-1:0]  BC_WORD    = BC_W'(DATA_W);
    localparam logic [WC_W-1:0]  WC_LAST    = WC_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [DIV_W-1:0]           div_cnt_q, div_cnt_d;
    logic [BC_W-1:0]            bit_cnt_q, bit_cnt_d;
    logic                       sck_q, sck_d;
    logic                       ws_q, ws_d;
    logic [CH_NUM-1:0]          sync1_q, sync1_d;
    logic [CH_NUM-1:0]          sync2_q, sync2_d;
    logic [CH_NUM*DATA_W-1:0]   shift_q, shift_d;
    logic [CH_NUM*DATA_W-1:0]   data_q, data_d;
    logic [IDX_W-1:0]           index_q, index_d;
    logic [WC_W-1:0]            word_cnt_q, word_cnt_d;
    logic                       valid_q, valid_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       overrun_q, overrun_d;

    logic sck_fall, strobe, take_bit, word_done, ws_fall, handshake;

    // Bit clock, bit position and WS all advance together on the SCK falling edge.
    always_comb begin
        sck_fall  = (div_cnt_q == DIV_FALL);
        div_cnt_d = sck_fall ? '0 : div_cnt_q + 1'b1;
        sck_d     = (sck_fall || div_cnt_q == DIV_RISE) ? ~sck_q : sck_q;
        bit_cnt_d = bit_cnt_q;
        if (sck_fall) begin
            bit_cnt_d = (bit_cnt_q == BC_LAST) ? '0 : bit_cnt_q + 1'b1;
        end
        ws_d      = (bit_cnt_d >= BC_SLOT);
        sync1_d   = mic_data_in;
        sync2_d   = sync1_q;
        strobe    = (div_cnt_q == DIV_STROBE);
        take_bit  = strobe && (bit_cnt_q != '0) && (bit_cnt_q <= BC_WORD);
        word_done = strobe && (bit_cnt_q == BC_WORD);
        ws_fall   = sck_fall && (bit_cnt_q == BC_LAST);
        handshake = valid_q && smp_ready;
    end

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        if (DATA_W == 1) begin : g_w1
            assign shift_d[c] = take_bit ? sync2_q[c] : shift_q[c];
        end else begin : g_wn
            assign shift_d[c*DATA_W +: DATA_W] = take_bit ?
                {shift_q[c*DATA_W +: DATA_W-1], sync2_q[c]} : shift_q[c*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overrun_d  = overrun_q;
        valid_d    = valid_q && !handshake;
        data_d     = data_q;
        index_d    = index_q;
        word_cnt_d = word_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cap_start) begin
                    state_d    = ST_SYNC;
                    busy_d     = 1'b1;
                    overrun_d  = 1'b0;
                    word_cnt_d = '0;
                    index_d    = '0;
                end
            end
            // Start on a frame boundary so a word already in flight is never emitted.
            ST_SYNC: begin
                if (ws_fall) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (word_done) begin
                    data_d     = shift_d;
                    valid_d    = 1'b1;
                    index_d    = IDX_W'(word_cnt_q);
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (valid_q && !smp_ready) begin
                        overrun_d = 1'b1;
                    end
                    if (word_cnt_q == WC_LAST) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (handshake) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_60MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            sck_q      <= 1'b0;
            ws_q       <= 1'b0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            index_q    <= '0;
            word_cnt_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sck_q      <= sck_d;
            ws_q       <= ws_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            index_q    <= index_d;
            word_cnt_q <= word_cnt_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    assign mic_sck   = sck_q;
    assign mic_ws    = ws_q;
    assign cap_busy  = busy_q;
    assign cap_done  = done_q;
    assign overrun   = overrun_q;
    assign smp_valid = valid_q;
    assign smp_data  = data_q;
    assign smp_index = index_q;

endmodule
`default_nettype wire

// File: tb/tb_mic_array_capture.sv
`default_nettype none
// ============================================================================
// Module : tb_mic_array_capture
// Brief  : Directed self-checking bench with an I2S mic model per channel.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mic_array_capture;

    localparam int CH = 4;
    localparam int DW = 24;
    localparam int FL = 4;
    localparam logic [CH*DW-1:0] EXP_PAT = {24'h7FFFFF, 24'h800003, 24'h800002, 24'h800001};
    localparam logic [CH*DW-1:0] EXP_SLOT = {4{24'h123456}};

    logic           clk_60MHz = 1'b0;
    logic           rst_n     = 1'b0;
    logic           cap_start = 1'b0;
    logic           smp_ready = 1'b0;
    logic [CH-1:0]  mic_data_in;
    logic           cap_busy, cap_done, overrun, mic_sck, mic_ws, smp_valid;
    logic [CH*DW-1:0] smp_data;
    logic [1:0]     smp_index;

    mic_array_capture #(
        .CH_NUM(CH), .DATA_W(DW), .SLOT_BITS(32), .SCK_DIV(30), .FRAME_LEN(FL)
    ) dut (
        .clk_60MHz(clk_60MHz), .rst_n(rst_n), .cap_start(cap_start),
        .cap_busy(cap_busy), .cap_done(cap_done), .overrun(overrun),
        .mic_sck(mic_sck), .mic_ws(mic_ws), .mic_data_in(mic_data_in),
        .smp_valid(smp_valid), .smp_ready(smp_ready),
        .smp_data(smp_data), .smp_index(smp_index)
    );

    always #5 clk_60MHz = ~clk_60MHz;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    // Mic model: each line shifts out a 32-bit left word MSB-first one SCK after WS falls.
    logic [31:0] left_w  [CH];
    logic [31:0] right_w [CH];
    bit          add_frame = 1'b0;
    int          p = 0;
    int          mic_frame = 0;
    logic [31:0] lw_t;
    int          idx_t;

    always @(negedge mic_sck or negedge rst_n) begin
        if (!rst_n) begin
            p = 0;
        end else begin
            p = (p == 63) ? 0 : p + 1;
            if (p == 0) mic_frame = mic_frame + 1;
        end
    end

    always_comb begin
        lw_t  = '0;
        idx_t = 0;
        for (int c = 0; c < CH; c++) begin
            lw_t = left_w[c] + (add_frame ? (32'(mic_frame) << 8) : 32'd0);
            if (p >= 1 && p <= 32) begin
                idx_t = 32 - p;
                mic_data_in[c] = lw_t[idx_t[4:0]];
            end else begin
                idx_t = (64 - p) % 32;
                mic_data_in[c] = right_w[c][idx_t[4:0]];
            end
        end
    end

    always @(posedge clk_60MHz) if (cap_done) done_cnt++;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_valid(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_60MHz);
            if (smp_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_start;
        @(negedge clk_60MHz);
        cap_start = 1'b1;
        @(negedge clk_60MHz);
        cap_start = 1'b0;
    endtask

    function automatic logic [CH*DW-1:0] ramp_exp(input int f);
        logic [CH*DW-1:0] v;
        for (int c = 0; c < CH; c++) v[c*DW +: DW] = 24'((c + 1) << 20) + 24'(f);
        return v;
    endfunction

    task automatic set_ramp;
        for (int c = 0; c < CH; c++) begin
            left_w[c]  = 32'(c + 1) << 28;
            right_w[c] = 32'h0;
        end
        add_frame = 1'b1;
    endtask

    task automatic set_pattern;
        left_w[0] = 32'h8000015A;
        left_w[1] = 32'h8000025A;
        left_w[2] = 32'h8000035A;
        left_w[3] = 32'h7FFFFF5A;
        for (int c = 0; c < CH; c++) right_w[c] = 32'h0;
        add_frame = 1'b0;
    endtask

    task automatic test_reset;
        set_pattern();
        rst_n = 1'b0;
        repeat (3) @(negedge clk_60MHz);
        n_tests++;
        if ({mic_sck, mic_ws, smp_valid, cap_busy, cap_done, overrun} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got sck/ws/valid/busy/done/ovr=%b required 000000",
                     {mic_sck, mic_ws, smp_valid, cap_busy, cap_done, overrun});
        end
        n_tests++;
        if (smp_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h required 0", smp_data);
        end
        n_tests++;
        if (smp_index !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_index: got %0d required 0", smp_index);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_clocks;
        int r1 = 0, r2 = 0, hi = 0, wr1 = 0, wr2 = 0, wf = 0, ws_bad = 0, idle_bad = 0;
        logic ps = 1'b0, pw = 1'b0;
        for (int k = 1; k <= 2900; k++) begin
            @(negedge clk_60MHz);
            if (mic_sck && !ps) begin
                if (r1 == 0) r1 = k;
                else if (r2 == 0) r2 = k;
            end
            if (r1 != 0 && r2 == 0 && mic_sck) hi++;
            if (mic_ws && !pw) begin
                if (wr1 == 0) wr1 = k;
                else if (wr2 == 0) wr2 = k;
            end
            if (!mic_ws && pw && wf == 0) wf = k;
            if (mic_ws !== pw && !(ps && !mic_sck)) ws_bad++;
            if (smp_valid || cap_busy) idle_bad++;
            ps = mic_sck;
            pw = mic_ws;
        end
        n_tests++;
        if (r1 !== 15) begin n_fail++; $display("FAIL sck_first_rise: got cycle %0d required 15", r1); end
        n_tests++;
        if (r2 - r1 !== 30) begin n_fail++; $display("FAIL sck_period: got %0d required 30", r2 - r1); end
        n_tests++;
        if (hi !== 15) begin n_fail++; $display("FAIL sck_high: got %0d required 15", hi); end
        n_tests++;
        if (wr1 !== 960 || wf !== 1920) begin
            n_fail++;
            $display("FAIL ws_edges: got rise %0d fall %0d required 960 1920", wr1, wf);
        end
        n_tests++;
        if (wr2 - wr1 !== 1920) begin n_fail++; $display("FAIL ws_period: got %0d required 1920", wr2 - wr1); end
        n_tests++;
        if (ws_bad !== 0) begin n_fail++; $display("FAIL ws_on_sck_fall: got %0d bad changes required 0", ws_bad); end
        n_tests++;
        if (idle_bad !== 0) begin n_fail++; $display("FAIL idle_quiet: got %0d active cycles required 0", idle_bad); end
    endtask

    task automatic test_pattern;
        bit ok;
        set_pattern();
        smp_ready = 1'b1;
        pulse_start();
        n_tests++;
        if (cap_busy !== 1'b1) begin n_fail++; $display("FAIL pat_busy: got %b required 1", cap_busy); end
        for (int i = 0; i < FL; i++) begin
            wait_valid(5000, ok);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL pat_timeout word %0d: smp_valid 0 required 1", i);
            end else begin
                n_tests++;
                if (smp_index !== 2'(i)) begin
                    n_fail++;
                    $display("FAIL pat_index: got %0d required %0d", smp_index, i);
                end
                n_tests++;
                if (smp_data !== EXP_PAT) begin
                    n_fail++;
                    $display("FAIL pat_data idx %0d: got %h required %h", i, smp_data, EXP_PAT);
                end
            end
        end
        @(negedge clk_60MHz);
        n_tests++;
        if (cap_done !== 1'b1 || cap_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL pat_done: got done %b busy %b required 1 0", cap_done, cap_busy);
        end
        @(negedge clk_60MHz);
        n_tests++;
        if (cap_done !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL pat_after: got done %b overrun %b required 0 0", cap_done, overrun);
        end
    endtask

    task automatic test_slots;
        bit ok;
        for (int c = 0; c < CH; c++) begin
            left_w[c]  = 32'h123456FF;
            right_w[c] = 32'hAAAAAAAA;
        end
        add_frame = 1'b0;
        smp_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < FL; i++) begin
            wait_valid(5000, ok);
            n_tests++;
            if (!ok || smp_data !== EXP_SLOT) begin
                n_fail++;
                $display("FAIL slot_data idx %0d: got %h (valid %b) required %h", i, smp_data, ok, EXP_SLOT);
            end
        end
        @(negedge clk_60MHz);
        n_tests++;
        if (cap_done !== 1'b1) begin n_fail++; $display("FAIL slot_done: got %b required 1", cap_done); end
    endtask

    task automatic test_overrun;
        bit ok = 1'b0;
        int d0;
        set_ramp();
        smp_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 11000; i++) begin
            @(negedge clk_60MHz);
            if (smp_valid && smp_index == 2'd2) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ovr_skip: smp_index %0d never reached required 2", smp_index);
        end
        n_tests++;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b required 1", overrun); end
        n_tests++;
        if (smp_data !== ramp_exp(mic_frame)) begin
            n_fail++;
            $display("FAIL ovr_latest: got %h required %h", smp_data, ramp_exp(mic_frame));
        end
        smp_ready = 1'b1;
        @(negedge clk_60MHz);
        smp_ready = 1'b0;
        n_tests++;
        if (smp_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_accept: got valid %b required 0", smp_valid); end
        wait_valid(5000, ok);
        n_tests++;
        if (!ok || smp_index !== 2'd3 || smp_data !== ramp_exp(mic_frame)) begin
            n_fail++;
            $display("FAIL ovr_last: got idx %0d data %h required 3 %h", smp_index, smp_data, ramp_exp(mic_frame));
        end
        d0 = done_cnt;
        repeat (20) @(negedge clk_60MHz);
        n_tests++;
        if (done_cnt !== d0 || cap_busy !== 1'b1 || smp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_drain: got dones %0d busy %b valid %b required 0 1 1", done_cnt - d0, cap_busy, smp_valid);
        end
        smp_ready = 1'b1;
        @(negedge clk_60MHz);
        smp_ready = 1'b0;
        n_tests++;
        if (cap_done !== 1'b1 || cap_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_done: got done %b busy %b required 1 0", cap_done, cap_busy);
        end
    endtask

    task automatic test_mid_start;
        bit ok;
        int f0;
        set_ramp();
        smp_ready = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_60MHz);
            if (p == 10) break;
        end
        f0 = mic_frame;
        pulse_start();
        wait_valid(5000, ok);
        n_tests++;
        if (!ok || smp_index !== 2'd0 || smp_data !== ramp_exp(f0 + 1)) begin
            n_fail++;
            $display("FAIL mid_first: got idx %0d data %h required 0 %h", smp_index, smp_data, ramp_exp(f0 + 1));
        end
        pulse_start();
        n_tests++;
        if (cap_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b required 1", cap_busy); end
        for (int i = 1; i < FL; i++) begin
            wait_valid(5000, ok);
            n_tests++;
            if (!ok || smp_index !== 2'(i) || smp_data !== ramp_exp(f0 + 1 + i)) begin
                n_fail++;
                $display("FAIL mid_word: got idx %0d data %h required %0d %h", smp_index, smp_data, i, ramp_exp(f0 + 1 + i));
            end
        end
        @(negedge clk_60MHz);
        n_tests++;
        if (cap_done !== 1'b1) begin n_fail++; $display("FAIL mid_done: got %b required 1", cap_done); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int d0, r1 = 0;
        set_pattern();
        smp_ready = 1'b0;
        pulse_start();
        wait_valid(5000, ok);
        repeat (5) @(negedge clk_60MHz);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({cap_busy, smp_valid, mic_sck, mic_ws, overrun} !== 5'b0 || smp_data !== '0 || smp_index !== 2'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: got busy/valid/sck/ws/ovr=%b data %h idx %0d required 0",
                     {cap_busy, smp_valid, mic_sck, mic_ws, overrun}, smp_data, smp_index);
        end
        smp_ready = 1'b1;
        repeat (3) @(negedge clk_60MHz);
        rst_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_60MHz);
            if (mic_sck && r1 == 0) r1 = k;
        end
        n_tests++;
        if (r1 !== 15) begin n_fail++; $display("FAIL rstmid_phase: got first rise %0d required 15", r1); end
        n_tests++;
        if (done_cnt !== d0) begin n_fail++; $display("FAIL rstmid_nodone: got %0d pulses required 0", done_cnt - d0); end
        pulse_start();
        for (int i = 0; i < FL; i++) begin
            wait_valid(5000, ok);
            n_tests++;
            if (!ok || smp_index !== 2'(i) || smp_data !== EXP_PAT) begin
                n_fail++;
                $display("FAIL rstmid_word: got idx %0d data %h required %0d %h", smp_index, smp_data, i, EXP_PAT);
            end
        end
        @(negedge clk_60MHz);
        n_tests++;
        if (cap_done !== 1'b1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_done: got done %b overrun %b required 1 0", cap_done, overrun);
        end
    endtask

    initial begin
        test_reset();
        test_clocks();
        test_pattern();
        test_slots();
        test_overrun();
        test_mid_start();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
